ecg_frame_streamer: RTL and testbench

Source side of the classifier core's sample interface. Accepts ECG samples from upstream over a valid/ready handshake and buffers one full frame. It then pulses start to the core and streams the frame at one sample per clock. After a fixed latency it captures the core's class output and reports it with a one-cycle valid. It sits between the acquisition front end and the top-level classifier.

---
 rtl/ecg_frame_streamer.sv | 199 +++++++++++++++++++
 tb/tb_ecg_frame_streamer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecg_frame_streamer.sv
// ecg_frame_streamer
// Buffers one frame of ECG samples from an upstream valid/ready source. Once the
// frame is full it pulses start to the classifier core, streams the frame at one
// sample per clock, waits a fixed latency, then captures the core's result and
// reports it with a one-cycle valid.
//
// Ports:
//   clk, rst          system clock (rising edge), synchronous active-high reset
//   in_data/in_valid  upstream sample and its valid
//   in_ready          streamer can accept a sample (IDLE and FILL only)
//   start             one-cycle frame-start pulse to the core
//   ecg_out/smp_valid streamed sample and its qualifier
//   classifier_in     result from the core
//   class_out         captured result, held until the next capture
//   class_valid       one-cycle pulse marking a fresh class_out
//   busy              high in every state except IDLE
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for the first sample of a frame
// ST_FILL   | accepting samples 1..FRAME_LEN-1
// ST_START  | start pulse to the core, nothing streamed
// ST_STREAM | driving frame sample rd_ptr on ecg_out
// ST_WAIT   | counting lat_cnt 1..RESULT_LAT before capturing the result
// ST_REPORT | class_valid high for one cycle
module ecg_frame_streamer #(
    parameter int DATA_W     = 8,
    parameter int FRAME_LEN  = 15,
    parameter int CLASS_W    = 4,
    parameter int RESULT_LAT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               start,
    output logic [DATA_W-1:0]  ecg_out,
    output logic               smp_valid,
    input  logic [CLASS_W-1:0] classifier_in,
    output logic [CLASS_W-1:0] class_out,
    output logic               class_valid,
    output logic               busy
);

    localparam int PTR_W = $clog2(FRAME_LEN);
    localparam int LAT_W = $clog2(RESULT_LAT + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_LEN - 1);
    localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(RESULT_LAT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_START,
        ST_STREAM,
        ST_WAIT,
        ST_REPORT
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   rd_nxt;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               start_q, start_d;
    logic [DATA_W-1:0]  ecg_out_q, ecg_out_d;
    logic               smp_valid_q, smp_valid_d;
    logic [CLASS_W-1:0] class_out_q, class_out_d;
    logic               class_valid_q, class_valid_d;
    logic               busy_q, busy_d;

    logic [DATA_W-1:0]  frame_q [FRAME_LEN];
    logic               wr_en;
    logic [PTR_W-1:0]   wr_idx;
    logic               hs;

    assign hs     = in_valid && in_ready_q;
    assign rd_nxt = rd_ptr_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        lat_cnt_d     = lat_cnt_q;
        ecg_out_d     = '0;
        smp_valid_d   = 1'b0;
        class_out_d   = class_out_q;
        class_valid_d = 1'b0;
        wr_en         = 1'b0;
        wr_idx        = wr_ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    wr_en    = 1'b1;
                    wr_idx   = '0;
                    wr_ptr_d = PTR_W'(1);
                    state_d  = ST_FILL;
                end
            end
            ST_FILL: begin
                if (hs) begin
                    wr_en = 1'b1;
                    if (wr_ptr_q == LAST_IDX) begin
                        wr_ptr_d = '0;
                        state_d  = ST_START;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            ST_START: begin
                // Sample 0 goes out in the cycle right after the start pulse.
                rd_ptr_d    = '0;
                ecg_out_d   = frame_q[0];
                smp_valid_d = 1'b1;
                state_d     = ST_STREAM;
            end
            ST_STREAM: begin
                if (rd_ptr_q == LAST_IDX) begin
                    // The last sample's cycle is latency cycle 0.
                    rd_ptr_d  = '0;
                    lat_cnt_d = LAT_W'(1);
                    state_d   = ST_WAIT;
                end else begin
                    rd_ptr_d    = rd_nxt;
                    ecg_out_d   = frame_q[rd_nxt];
                    smp_valid_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == LAT_END) begin
                    class_out_d   = classifier_in;
                    class_valid_d = 1'b1;
                    lat_cnt_d     = '0;
                    state_d       = ST_REPORT;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered copies of what the next state implies.
        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_FILL);
        start_d    = (state_d == ST_START);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            lat_cnt_q     <= '0;
            in_ready_q    <= 1'b1;
            start_q       <= 1'b0;
            ecg_out_q     <= '0;
            smp_valid_q   <= 1'b0;
            class_out_q   <= '0;
            class_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            lat_cnt_q     <= lat_cnt_d;
            in_ready_q    <= in_ready_d;
            start_q       <= start_d;
            ecg_out_q     <= ecg_out_d;
            smp_valid_q   <= smp_valid_d;
            class_out_q   <= class_out_d;
            class_valid_q <= class_valid_d;
            busy_q        <= busy_d;
        end
    end

    // Frame storage needs no reset: every entry is rewritten before it is streamed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            frame_q[wr_idx] <= in_data;
        end
    end

    assign in_ready    = in_ready_q;
    assign start       = start_q;
    assign ecg_out     = ecg_out_q;
    assign smp_valid   = smp_valid_q;
    assign class_out   = class_out_q;
    assign class_valid = class_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ecg_frame_streamer.sv
// Testbench for ecg_frame_streamer: table of whole-frame vectors plus directed
// sequences for backpressure, capture timing and mid-frame reset.
module tb_ecg_frame_streamer;

    localparam int DW = 8;
    localparam int FL = 15;
    localparam int CW = 4;
    localparam int RL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          start;
    logic [DW-1:0] ecg_out;
    logic          smp_valid;
    logic [CW-1:0] classifier_in;
    logic [CW-1:0] class_out;
    logic          class_valid;
    logic          busy;

    always #5 clk = ~clk;

    ecg_frame_streamer #(
        .DATA_W(DW), .FRAME_LEN(FL), .CLASS_W(CW), .RESULT_LAT(RL)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .start(start), .ecg_out(ecg_out), .smp_valid(smp_valid),
        .classifier_in(classifier_in), .class_out(class_out),
        .class_valid(class_valid), .busy(busy)
    );

    typedef struct {
        logic [FL-1:0][DW-1:0] smp;
        bit                    gapped;
        logic [CW-1:0]         cls;
        string                 tag;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Monitor: records events with the index of the negedge they were seen on.
    int            cyc = 0;
    logic [DW-1:0] stream_q[$];
    int            smp_cyc_q[$];
    int            start_cyc_q[$];
    logic [CW-1:0] cls_q[$];
    int            cls_cyc_q[$];

    always @(negedge clk) begin
        cyc++;
        if (start) start_cyc_q.push_back(cyc);
        if (smp_valid) begin
            stream_q.push_back(ecg_out);
            smp_cyc_q.push_back(cyc);
        end
        if (class_valid) begin
            cls_q.push_back(class_out);
            cls_cyc_q.push_back(cyc);
        end
    end

    int b_smp, b_start, b_cls;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bounded wait expired", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        b_smp   = stream_q.size();
        b_start = start_cyc_q.size();
        b_cls   = cls_q.size();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_ecg_out"}, ecg_out, 0);
        chk({tag, "_smp_valid"}, smp_valid, 0);
        chk({tag, "_class_valid"}, class_valid, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Sends s[first..FL-1]; gapped inserts two idle cycles after each handshake.
    task automatic send(input logic [FL-1:0][DW-1:0] s, input int first, input bit gapped,
                        input bit keep, input logic [DW-1:0] hold, input string tag);
        for (int i = first; i < FL; i++) begin
            int budget;
            bit hs;
            budget = 0;
            hs = 0;
            if (i == FL - 1)
                chk({tag, "_no_early_start"}, start_cyc_q.size() - b_start, 0);
            in_data  = s[i];
            in_valid = 1'b1;
            while (!hs && budget < 50) begin
                hs = in_ready;
                step();
                budget++;
            end
            if (!hs) fail_now({tag, "_handshake"});
            if (gapped && i < FL - 1) begin
                in_valid = 1'b0;
                step();
                step();
            end
        end
        chk({tag, "_in_ready_drop"}, in_ready, 0);
        chk({tag, "_start_pulse"}, start, 1);
        if (keep) begin
            in_data  = hold;
            in_valid = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic finish(input logic [FL-1:0][DW-1:0] s, input logic [CW-1:0] cls,
                          input string tag);
        int budget;
        budget = 0;
        classifier_in = cls;
        while (class_valid !== 1'b1 && budget < 100) begin
            step();
            budget++;
        end
        if (class_valid !== 1'b1) begin
            fail_now({tag, "_class_valid"});
        end else begin
            chk({tag, "_class_out"}, class_out, cls);
            chk({tag, "_n_start"}, start_cyc_q.size() - b_start, 1);
            chk({tag, "_n_smp"}, stream_q.size() - b_smp, FL);
            if (stream_q.size() - b_smp == FL && start_cyc_q.size() - b_start == 1) begin
                for (int i = 0; i < FL; i++)
                    chk($sformatf("%s_smp%0d", tag, i), stream_q[b_smp + i], s[i]);
                chk({tag, "_first_smp_lat"}, smp_cyc_q[b_smp] - start_cyc_q[b_start], 1);
                chk({tag, "_smp_contig"}, smp_cyc_q[b_smp + FL - 1] - smp_cyc_q[b_smp], FL - 1);
                // This cycle's negedge will be cyc+1; WAIT cycles 1..RL, REPORT after.
                chk({tag, "_result_lat"}, (cyc + 1) - smp_cyc_q[b_smp + FL - 1], RL + 1);
            end
            step();
            chk({tag, "_class_valid_1cyc"}, class_valid, 0);
            chk({tag, "_busy_fall"}, busy, 0);
            chk({tag, "_ready_back"}, in_ready, 1);
            chk({tag, "_class_hold"}, class_out, cls);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t                  vecs[4];
        logic [FL-1:0][DW-1:0] s;
        logic [FL-1:0][DW-1:0] s2;
        int                    budget;
        int                    ncls;
        int                    nstart;

        vecs[0].smp    = {8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h06, 8'h06,
                          8'h05, 8'h03, 8'h00, 8'h03, 8'h07, 8'h0F, 8'h10};
        vecs[0].gapped = 0;
        vecs[0].cls    = 4'b0010;
        vecs[0].tag    = "basic";
        for (int i = 0; i < FL; i++) vecs[1].smp[i] = 8'hA1 + 8'(i);
        vecs[1].gapped = 1;
        vecs[1].cls    = 4'b0101;
        vecs[1].tag    = "gapped";
        for (int i = 0; i < FL; i++) vecs[2].smp[i] = 8'hF0 - 8'(3 * i);
        vecs[2].gapped = 0;
        vecs[2].cls    = 4'b0100;
        vecs[2].tag    = "b2b_a";
        for (int i = 0; i < FL; i++) vecs[3].smp[i] = 8'h5A ^ 8'(i << 3);
        vecs[3].gapped = 0;
        vecs[3].cls    = 4'b1000;
        vecs[3].tag    = "b2b_b";

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        classifier_in = '0;
        step();
        step();
        check_reset_vals("reset");
        chk("reset_class_out", class_out, 0);
        rst = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            mark();
            send(vecs[v].smp, 0, vecs[v].gapped, 1'b0, 8'h00, vecs[v].tag);
            finish(vecs[v].smp, vecs[v].cls, vecs[v].tag);
        end
        if (cls_q.size() >= 2) begin
            chk("b2b_order_a", cls_q[cls_q.size() - 2], 4'b0100);
            chk("b2b_order_b", cls_q[cls_q.size() - 1], 4'b1000);
        end else begin
            fail_now("b2b_order");
        end

        // Backpressure: 0xAA held valid through STREAM/WAIT/REPORT.
        for (int i = 0; i < FL; i++) s[i] = 8'h30 + 8'(i);
        mark();
        send(s, 0, 1'b0, 1'b1, 8'hAA, "bp");
        finish(s, 4'b0011, "bp");
        s2[0] = 8'hAA;
        for (int i = 1; i < FL; i++) s2[i] = 8'h40 + 8'(i);
        mark();
        step();
        chk("bp_aa_accepted_busy", busy, 1);
        send(s2, 1, 1'b0, 1'b0, 8'h00, "bp2");
        finish(s2, 4'b1001, "bp2");

        // Capture timing: result changes only in WAIT cycle RL.
        for (int i = 0; i < FL; i++) s[i] = 8'h50 + 8'(i);
        mark();
        send(s, 0, 1'b0, 1'b0, 8'h00, "cap");
        classifier_in = 4'b0001;
        budget = 0;
        while (smp_valid !== 1'b1 && budget < 20) begin step(); budget++; end
        while (smp_valid === 1'b1 && budget < 40) begin step(); budget++; end
        if (budget >= 40) begin
            fail_now("cap_stream");
        end else begin
            for (int j = 1; j < RL; j++) begin
                chk($sformatf("cap_early_valid%0d", j), class_valid, 0);
                step();
            end
            classifier_in = 4'b1000;
            chk("cap_wait_last", class_valid, 0);
            step();
            classifier_in = 4'b0001;
            chk("cap_valid", class_valid, 1);
            chk("cap_value", class_out, 4'b1000);
            step();
            chk("cap_idle", busy, 0);
        end

        // Reset in the middle of streaming.
        for (int i = 0; i < FL; i++) s[i] = 8'h60 + 8'(i);
        mark();
        send(s, 0, 1'b0, 1'b0, 8'h00, "rst_abort");
        budget = 0;
        while (!(smp_valid === 1'b1 && ecg_out == s[6]) && budget < 30) begin
            step();
            budget++;
        end
        if (budget >= 30) fail_now("rst_reach_smp6");
        rst = 1'b1;
        step();
        check_reset_vals("rst_mid1");
        step();
        rst = 1'b0;
        check_reset_vals("rst_mid2");
        ncls = cls_q.size();
        nstart = start_cyc_q.size();
        for (int j = 0; j < 30; j++) step();
        chk("rst_no_class", cls_q.size() - ncls, 0);
        chk("rst_no_start", start_cyc_q.size() - nstart, 0);
        for (int i = 0; i < FL; i++) s[i] = 8'h01 + 8'(i);
        mark();
        send(s, 0, 1'b0, 1'b0, 8'h00, "rst_new");
        finish(s, 4'b0110, "rst_new");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
